// File: rtl/nibble_add_seq.sv
// Multi-precision adder sequencer: one nibble per clock through an external 4-bit adder.
// Optional signed-overflow flag on out_ovf when NIBBLE_ADD_SEQ_OVF_EN is defined.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_ci,
    input  logic [3:0]             add_s,
    input  logic                   add_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    output logic                   out_ovf,
`endif
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [W-1:0]    w_sum_shift;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_cout;
    logic            w_accept;
    logic            w_run;
    logic            w_last;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_idx == LAST);
    assign out_sum  = r_sum;
    assign out_cout = r_cout;

    // Sum nibbles enter at the top so nibble 0 ends at the LSB.
    if (NIBBLES == 1) begin : g_one
        assign w_sum_shift = add_s;
    end else begin : g_multi
        assign w_sum_shift = {add_s, r_sum[W-1:4]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_ci    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                add_a  = r_a[3:0];
                add_b  = r_b[3:0];
                add_ci = r_carry;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
        end else if (w_run) begin
            r_sum   <= w_sum_shift;
            r_carry <= add_co;
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_idx   <= r_idx + 1'b1;
            if (w_last) r_cout <= add_co;
        end
    end

`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic r_ovf;

    assign out_ovf = r_ovf;

    // In the last RUN cycle the operand top nibbles sit at bits [3:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[3] == r_b[3]) && (add_s[3] != r_a[3]);
        end else if ((r_state == S_DONE) && out_ready) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq with a behavioural 4-bit adder slice.
// Random and directed operand sets are compared against plain-arithmetic expectations.
module tb_nibble_add_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_ci;
    logic [3:0]   add_s;
    logic         add_co;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic         out_ovf;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // External adder slice; drives X when the sequencer is not running.
    assign {add_co, add_s} = busy ?
        ({1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci}) : 5'bx;

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [W:0] got,
                       input logic [W:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", in_ready, 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int hold);
        logic [W:0]  full;
        logic [63:0] m;
        logic [63:0] c;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        wait_ready();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        tick();
        for (int k = 0; k < N; k++) begin
            // Junk operands and early out_ready must both be ignored in RUN.
            in_valid  = 1'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = 1'($urandom);
            m = (64'd1 << (4 * k)) - 64'd1;
            c = ((64'(a) & m) + (64'(b) & m) + 64'(cin)) >> (4 * k);
            chk("busy_run", busy, 1);
            chk("in_ready_run", in_ready, 0);
            chk("out_valid_run", out_valid, 0);
            chk("add_a", add_a, (a >> (4 * k)) & 'hF);
            chk("add_b", add_b, (b >> (4 * k)) & 'hF);
            chk("add_ci", add_ci, c[0]);
            tick();
        end
        out_ready = 1'b0;
        chk("out_valid_done", out_valid, 1);
        chk("out_sum", out_sum, full[W-1:0]);
        chk("out_cout", out_cout, full[W]);
        chk("add_a_idle", add_a, 0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        chk("out_ovf", out_ovf, ovf);
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, full[W-1:0]);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        chk("post_ovf", out_ovf, 0);
`endif
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add", {add_a, add_b, add_ci}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        do_op(16'h0000, 16'h0001, 1'b1, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h0F0F, 16'hF0F0, 1'b1, 1);
        do_op(16'h8000, 16'h0001, 1'b0, 3);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0);

        // Reset in the second RUN cycle discards the partial result.
        wait_ready();
        in_valid = 1'b1;
        in_a = 16'h1234;
        in_b = 16'h1111;
        in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_busy_rst", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_sum", out_sum, 0);
        chk("mid_out_cout", out_cout, 0);
        chk("mid_add", {add_a, add_b, add_ci}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_valid", out_valid, 0);
        end
        do_op(16'h0006, 16'h0009, 1'b1, 0);

`ifdef NIBBLE_ADD_SEQ_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h1000, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 1);
`endif

        for (int i = 0; i < 25; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
